// File: rtl/s27_array_pkg.sv
// Shared types and helpers for the s27 scan array: state layout, chain length, MISR step.
package s27_array_pkg;

   localparam int STATE_BITS = 3;
   localparam int MISR_MAX   = 64;

   // g5 sits in bit 0 so a flattened state vector is already in scan-chain order.
   typedef struct packed {
      logic g7;
      logic g6;
      logic g5;
   } s27_state_t;

   function automatic int CHAIN_LEN(input int nch);
      return STATE_BITS * nch;
   endfunction

   // Galois MISR step; callers zero-extend their operands and truncate the result.
   function automatic logic [MISR_MAX-1:0] misr_next(input logic [MISR_MAX-1:0] sig,
                                                     input logic [MISR_MAX-1:0] poly,
                                                     input logic [MISR_MAX-1:0] din);
      return (sig >> 1) ^ (sig[0] ? poly : '0) ^ din;
   endfunction

endpackage

// File: rtl/s27_core.sv
// Combinational next-state and output logic of one s27 channel.
module s27_core (
   input  logic i_g0,
   input  logic i_g1,
   input  logic i_g2,
   input  logic i_g3,
   input  logic i_g5,
   input  logic i_g6,
   input  logic i_g7,
   output logic o_g10,
   output logic o_g11,
   output logic o_g13,
   output logic o_g17
);

   logic w_g8, w_g9, w_g12, w_g14, w_g15, w_g16;

   assign w_g14 = ~i_g0;
   assign w_g8  = w_g14 & i_g6;
   assign w_g12 = ~(i_g1 | i_g7);
   assign w_g15 = w_g12 | w_g8;
   assign w_g16 = i_g3 | w_g8;
   assign w_g9  = ~(w_g16 & w_g15);
   assign o_g11 = ~(i_g5 | w_g9);
   assign o_g10 = ~(w_g14 | o_g11);
   assign o_g13 = ~(i_g2 | w_g12);
   assign o_g17 = ~o_g11;

endmodule

// File: rtl/s27_scan_array.sv
// NCH s27 channels sharing a scan chain, plus a windowed MISR over the G17 outputs.
module s27_scan_array
   import s27_array_pkg::*;
#(
   parameter int              NCH       = 4,
   parameter int              MISR_W    = 16,
   parameter logic [MISR_W-1:0] MISR_POLY = 16'hB400,
   parameter int              WIN       = 64
) (
   input  logic              CK,
   input  logic              RST,
   input  logic              EN,
   input  logic              SE,
   input  logic              SI,
   input  logic [NCH-1:0]    G0,
   input  logic [NCH-1:0]    G1,
   input  logic [NCH-1:0]    G2,
   input  logic [NCH-1:0]    G3,
   output logic [NCH-1:0]    G17,
   output logic              SO,
   output logic [MISR_W-1:0] SIG,
   output logic              DONE
);

   localparam int CL = CHAIN_LEN(NCH);
   localparam int CW = (WIN > 1) ? $clog2(WIN) : 1;

   s27_state_t [NCH-1:0] r_st;
   logic [CW-1:0]        r_cnt;
   logic [MISR_W-1:0]    r_sig;
   logic                 r_done;

   logic [NCH-1:0]       w_g10, w_g11, w_g13;
   logic [CL-1:0]        w_chain;
   logic [MISR_W-1:0]    w_sig_nxt;

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_ch
         s27_core u_core (
            .i_g0  (G0[gi]),
            .i_g1  (G1[gi]),
            .i_g2  (G2[gi]),
            .i_g3  (G3[gi]),
            .i_g5  (r_st[gi].g5),
            .i_g6  (r_st[gi].g6),
            .i_g7  (r_st[gi].g7),
            .o_g10 (w_g10[gi]),
            .o_g11 (w_g11[gi]),
            .o_g13 (w_g13[gi]),
            .o_g17 (G17[gi])
         );
      end
   endgenerate

   assign w_chain   = r_st;
   assign w_sig_nxt = MISR_W'(misr_next(MISR_MAX'(r_sig), MISR_MAX'(MISR_POLY), MISR_MAX'(G17)));

   always_ff @(posedge CK) begin
      if (RST) begin
         r_st   <= '0;
         r_sig  <= '0;
         r_cnt  <= '0;
         r_done <= 1'b0;
      end else if (SE) begin
         r_st <= {w_chain[CL-2:0], SI};
      end else if (EN) begin
         for (int c = 0; c < NCH; c++) begin
            r_st[c].g5 <= w_g10[c];
            r_st[c].g6 <= w_g11[c];
            r_st[c].g7 <= w_g13[c];
         end
         // Counter stops at WIN-1 so it never wraps once the window closes.
         if (!r_done) begin
            r_sig <= w_sig_nxt;
            if (r_cnt == CW'(WIN - 1)) r_done <= 1'b1;
            else                       r_cnt  <= r_cnt + 1'b1;
         end
      end
   end

   assign SO   = r_st[NCH-1].g7;
   assign SIG  = r_sig;
   assign DONE = r_done;

endmodule

// File: tb/tb_s27_scan_array.sv
// Randomized + directed bench for s27_scan_array against a behavioural model.
module tb_s27_scan_array;

   localparam int          NCH  = 4;
   localparam int          MW   = 16;
   localparam int          WIN  = 4;
   localparam logic [15:0] POLY = 16'hB400;
   localparam int          CL   = 3 * NCH;

   logic CK = 1'b0;
   logic RST = 1'b0, EN = 1'b0, SE = 1'b0, SI = 1'b0;
   logic [NCH-1:0] G0 = '0, G1 = '0, G2 = '0, G3 = '0;
   logic [NCH-1:0] G17;
   logic SO;
   logic [MW-1:0] SIG;
   logic DONE;

   int errors = 0;
   int checks = 0;

   always #5 CK = ~CK;

   s27_scan_array #(.NCH(NCH), .MISR_W(MW), .MISR_POLY(POLY), .WIN(WIN)) dut (
      .CK(CK), .RST(RST), .EN(EN), .SE(SE), .SI(SI),
      .G0(G0), .G1(G1), .G2(G2), .G3(G3),
      .G17(G17), .SO(SO), .SIG(SIG), .DONE(DONE)
   );

   // Model: chain as a flat bit array q[3c+0..2] = {g5,g6,g7} of channel c.
   bit            q[CL];
   logic [MW-1:0] msig;
   int            mcnt;
   bit            mdone;
   bit            mvalid = 0;

   function automatic void ch_eval(input bit s5, s6, s7, a0, a1, a2, a3,
                                   output bit n5, n6, n7, o17);
      bit g14, g8, g12, g15, g16, g9, g11;
      g14 = !a0;          g8  = g14 & s6;
      g12 = !(a1 | s7);   g15 = g12 | g8;
      g16 = a3 | g8;      g9  = !(g16 & g15);
      g11 = !(s5 | g9);
      n5 = !(g14 | g11);  n6 = g11;
      n7 = !(a2 | g12);   o17 = !g11;
   endfunction

   function automatic logic [NCH-1:0] model_g17();
      logic [NCH-1:0] v;
      bit n5, n6, n7, o;
      for (int c = 0; c < NCH; c++) begin
         ch_eval(q[3*c], q[3*c+1], q[3*c+2], G0[c], G1[c], G2[c], G3[c], n5, n6, n7, o);
         v[c] = o;
      end
      return v;
   endfunction

   always @(posedge CK) begin
      bit nq[CL];
      bit n5, n6, n7, o;
      logic [NCH-1:0] v;
      if (RST) begin
         for (int k = 0; k < CL; k++) q[k] = 0;
         msig = '0; mcnt = 0; mdone = 0; mvalid = 1;
      end else if (mvalid && SE) begin
         for (int k = CL - 1; k > 0; k--) q[k] = q[k-1];
         q[0] = SI;
      end else if (mvalid && EN) begin
         v = model_g17();
         for (int c = 0; c < NCH; c++) begin
            ch_eval(q[3*c], q[3*c+1], q[3*c+2], G0[c], G1[c], G2[c], G3[c], n5, n6, n7, o);
            nq[3*c] = n5; nq[3*c+1] = n6; nq[3*c+2] = n7;
         end
         for (int k = 0; k < CL; k++) q[k] = nq[k];
         if (!mdone) begin
            msig = (msig >> 1) ^ (msig[0] ? POLY : 16'h0) ^ MW'(v);
            mcnt++;
            if (mcnt == WIN) mdone = 1;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model.
   always @(negedge CK) begin
      if (mvalid) begin
         chk("g17", 32'(G17), 32'(model_g17()));
         chk("so", 32'(SO), 32'(q[CL-1]));
         chk("sig", 32'(SIG), 32'(msig));
         chk("done", 32'(DONE), 32'(mdone));
      end
   end

   task automatic step(input bit r, input bit se, input bit en, input bit si);
      RST = r; SE = se; EN = en; SI = si;
      @(posedge CK); #1;
      RST = 0; SE = 0; EN = 0; SI = 0;
   endtask

   task automatic set_g(input logic [NCH-1:0] a0, a1, a2, a3);
      G0 = a0; G1 = a1; G2 = a2; G3 = a3; #1;
   endtask

   task automatic rnd_g();
      G0 = NCH'($urandom); G1 = NCH'($urandom); G2 = NCH'($urandom); G3 = NCH'($urandom);
   endtask

   initial begin
      logic [MW-1:0] saved;
      int ops[9];

      // Reset state
      step(1, 0, 0, 0);
      set_g('0, '0, '0, '1);
      chk("rst_g17_a", 32'(G17), 32'h0);
      chk("rst_so", 32'(SO), 32'h0);
      chk("rst_sig", 32'(SIG), 32'h0);
      chk("rst_done", 32'(DONE), 32'h0);
      set_g('0, '0, '0, '0);
      chk("rst_g17_b", 32'(G17), 32'hF);

      // Single step -> (0,1,0); all channels identical so SO shows ch3.G7
      set_g('0, '0, '0, '1);
      step(0, 0, 1, 0);
      chk("step1_model", {29'd0, q[0], q[1], q[2]}, 32'b010);
      chk("step1_so", 32'(SO), 32'h0);

      step(1, 0, 0, 0);
      set_g('1, '1, '0, '1);
      step(0, 0, 1, 0);
      chk("step2_model", {29'd0, q[0], q[1], q[2]}, 32'b101);
      chk("step2_so", 32'(SO), 32'h1);
      step(0, 0, 1, 0);
      chk("step3_model", {29'd0, q[0], q[1], q[2]}, 32'b101);
      chk("step3_so", 32'(SO), 32'h1);

      // Scan: single 1 walks the 12-bit chain
      step(1, 0, 0, 0);
      set_g('0, '0, '0, '1);
      for (int k = 1; k <= 13; k++) begin
         step(0, 1, 0, (k == 1));
         chk("scan_so", 32'(SO), (k == 12) ? 32'h1 : 32'h0);
      end
      chk("scan_sig", 32'(SIG), 32'h0);
      chk("scan_done", 32'(DONE), 32'h0);

      // MISR: G17 = 0001 then 0000
      step(1, 0, 0, 0);
      set_g('0, '0, '0, 4'b1110);
      chk("misr_in1", 32'(G17), 32'h1);
      step(0, 0, 1, 0);
      chk("misr_sig1", 32'(SIG), 32'h0001);
      set_g('0, '0, '0, '1);
      chk("misr_in2", 32'(G17), 32'h0);
      step(0, 0, 1, 0);
      chk("misr_sig2", 32'(SIG), 32'hB400);

      // Window: 1=functional, 0=idle, 2=scan
      step(1, 0, 0, 0);
      ops = '{1, 0, 2, 1, 2, 0, 1, 2, 1};
      for (int k = 0; k < 9; k++) begin
         rnd_g();
         if (k == 8) chk("win_done_before", 32'(DONE), 32'h0);
         step(0, ops[k] == 2, ops[k] == 1, $urandom_range(0, 1));
      end
      chk("win_done_after", 32'(DONE), 32'h1);
      saved = SIG;
      for (int k = 0; k < 3; k++) begin
         rnd_g();
         step(0, 0, 1, 0);
      end
      chk("win_sig_frozen", 32'(SIG), 32'(saved));
      chk("win_done_held", 32'(DONE), 32'h1);
      step(1, 0, 0, 0);
      chk("win_rst_done", 32'(DONE), 32'h0);
      chk("win_rst_sig", 32'(SIG), 32'h0);

      // Priority: SE over EN, RST over SE
      set_g('0, '0, '0, '0);
      step(0, 1, 1, 1);
      chk("prio_se_sig", 32'(SIG), 32'h0);
      chk("prio_se_model", 32'(q[0]), 32'h1);
      step(1, 1, 0, 1);
      for (int k = 0; k < CL; k++) begin
         step(0, 1, 0, 0);
         chk("prio_rst_chain", 32'(SO), 32'h0);
      end

      // Randomized traffic
      for (int n = 0; n < 4000; n++) begin
         rnd_g();
         step($urandom_range(0, 149) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 1) == 1, $urandom_range(0, 1));
      end

      @(negedge CK);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/s27_scan_array.md
# s27_scan_array

Parametrised, scan-testable array of NCH independent s27-class benchmark sequential cores. All cores share clock, synchronous reset and control. The block adds a serial scan chain through all state bits and a MISR that compacts the per-channel outputs over a programmable window. It is the next-generation benchmark/DFT test vehicle for gate-level flow and fault-simulation experiments.

## Interface
- NCH, 4: number of channels; 1..MISR_W
- MISR_W, 16: signature register width
- MISR_POLY, 16'hB400: Galois feedback taps, MISR_W bits wide
- WIN, 64: functional cycles compacted before DONE; ≥1
- CK  input  1  clock, rising edge
- RST  input  1  synchronous, active-high reset
- EN  input  1  functional-step enable
- SE  input  1  scan enable; overrides EN
- SI  input  1  scan-in
- G0, G1, G2, G3  input  NCH each  per-channel primary inputs; bit i drives channel i
- G17  output  NCH  per-channel primary output, combinational
- SO  output  1  scan-out; equals channel NCH-1 G7 register
- SIG  output  MISR_W  signature register
- DONE  output  1  window complete; SIG frozen

## Operation
- Per-channel state registers: G5, G6, G7.
- Per-channel combinational equations:
  - G14 = ~G0
  - G8 = G14 & G6
  - G12 = ~(G1 | G7)
  - G15 = G12 | G8
  - G16 = G3 | G8
  - G9 = ~(G16 & G15)
  - G11 = ~(G5 | G9)
  - G10 = ~(G14 | G11)
  - G13 = ~(G2 | G12)
  - G17 = ~G11
- Next state: G5←G10, G6←G11, G7←G13.
- Mode priority at each CK edge: RST > SE > EN > hold.
  - RST: all state bits 0, SIG 0, window counter 0, DONE 0.
  - SE=1: scan shift. Chain order: SI→ch0.G5→ch0.G6→ch0.G7→ch1.G5→…→ch(NCH-1).G7→SO. Chain length is 3·NCH. SIG, counter and DONE hold.
  - SE=0, EN=1: functional step. All channels update. If DONE=0, SIG ← (SIG>>1) ^ (SIG[0] ? MISR_POLY : 0) ^ zero-extended G17 vector, and the counter increments. When the counter reaches WIN-1 on a functional step, DONE←1 at that same edge. From then on SIG and the counter freeze; channels keep stepping.
  - SE=0, EN=0: every register holds.
- Once set, DONE clears only on RST.
- G17 is sampled into the MISR using the pre-edge state and inputs.
- Reset state output: G17 = G1 | ~G3 per channel.

## Timing
- Functional state latency: 1 cycle. G17 has zero latency (combinational from state and inputs).
- SO is registered. A bit presented on SI at shift edge k appears on SO after edge k+3·NCH-1.
- SIG includes a G17 sample 1 cycle after that functional step. DONE is high after exactly WIN functional edges; scan and idle cycles are not counted.
- Reset mid-scan or mid-window discards all progress. There is no partial-state retention.
- SE toggling during a window is legal; the window resumes on return to functional mode.

## Structure
- Package s27_array_pkg holds:
  - constants STATE_BITS=3 and CHAIN_LEN function (3·NCH)
  - typedef for per-channel state struct {g5, g6, g7}
  - MISR next-value function
- Sub-module s27_core: the combinational next-state/output logic of one channel (inputs G0–G3 and state; outputs G10, G11, G13, G17). The top instantiates NCH of these in a generate loop and owns all registers, the scan mux, the MISR, the counter and DONE.

## Test plan
- Reset: RST=1 for 1 cycle, then G1=0, G3=1 on all channels → state 0, SO=0, SIG=0, DONE=0, G17=4'b0000. With G3=0 instead → G17=4'b1111.
- Single step (NCH=4): from reset, ch0 G1=0, G3=1, EN=1 → ch0 next state (G5,G6,G7)=(0,1,0). Same start with G0=1, G1=1, G2=0, G3=1 → (1,0,1), and (1,0,1) persists on further steps.
- Scan (NCH=4): after reset, SE=1, SI=1 for one edge then 0 → SO=0 for edges 1–11, SO=1 after edge 12, 0 after edge 13. SIG stays 0 and DONE stays 0 throughout.
- MISR: after reset, one functional step with G17 vector 4'b0001 → SIG=16'h0001. Next step with G17=0 → SIG=16'hB400.
- Window (WIN=4): interleave 2 EN=0 cycles and 3 SE=1 cycles among 4 functional steps → DONE rises exactly at the 4th functional edge. SIG is unchanged by further steps. RST clears DONE and SIG.
- Priority: SE=1 and EN=1 together → shift only, no SIG update. RST=1 together with SE=1 → reset wins, chain all zeros.
